// File: rtl/ir_pkg.sv
// Shared IR definitions: transmit states and default timing, so encoder and decoder agree.
package ir_pkg;

  localparam int unsigned DEF_SBD            = 240_000;
  localparam int unsigned DEF_BSD            = 60_000;
  localparam int unsigned DEF_BBD0           = 60_000;
  localparam int unsigned DEF_BBD1           = 120_000;
  localparam int unsigned DEF_MARGIN         = 6_000;
  localparam int unsigned DEF_GAP            = 240_000;
  localparam int unsigned DEF_MESSAGE_LENGTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_MARK  = 3'd2,
    ST_SPACE = 3'd3,
    ST_GAP   = 3'd4
  } ir_tx_state_t;

  // Larger of two unsigned values, used to size duration counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_interval_timer.sv
// Down-counting interval timer: load N-1 on entry to a level, expired_c flags its last cycle.
module ir_interval_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/ir_encoder.sv
// IR transmit encoder: serialises a code MSB first as sync / (mark, space)* / gap on an idle-high line.
module ir_encoder
  import ir_pkg::*;
#(
  parameter int unsigned SBD            = DEF_SBD,
  parameter int unsigned BSD            = DEF_BSD,
  parameter int unsigned BBD0           = DEF_BBD0,
  parameter int unsigned BBD1           = DEF_BBD1,
  parameter int unsigned GAP            = DEF_GAP,
  parameter int unsigned MESSAGE_LENGTH = DEF_MESSAGE_LENGTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [MESSAGE_LENGTH-1:0] data_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic                      signal_out,
  output logic                      done_out,
  output logic [2:0]                state_out
);

  localparam int unsigned MAX_DUR = max_u(max_u(max_u(SBD, BSD), max_u(BBD0, BBD1)), GAP);
  localparam int unsigned CNT_W   = $clog2(MAX_DUR) + 1;
  localparam int unsigned BIT_W   = $clog2(MESSAGE_LENGTH + 1);

  // Each level lasts N cycles: load N-1 on entry, leave when the timer reads zero.
  localparam logic [CNT_W-1:0] LD_SBD  = CNT_W'(SBD - 1);
  localparam logic [CNT_W-1:0] LD_BSD  = CNT_W'(BSD - 1);
  localparam logic [CNT_W-1:0] LD_BBD0 = CNT_W'(BBD0 - 1);
  localparam logic [CNT_W-1:0] LD_BBD1 = CNT_W'(BBD1 - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MESSAGE_LENGTH - 1);

  // Reject parameter sets that cannot produce a decodable frame.
  if (SBD < 1 || BSD < 1 || BBD0 < 1 || BBD1 < 1 || GAP < 1 ||
      BBD0 == BBD1 || MESSAGE_LENGTH < 2) begin : g_param_err
    $error("ir_encoder: durations must be >= 1, BBD0 != BBD1, MESSAGE_LENGTH >= 2");
  end

  ir_tx_state_t              state_q, state_d;
  logic [MESSAGE_LENGTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      signal_q, signal_d;
  logic                      done_q, done_d;
  logic                      tmr_load;
  logic [CNT_W-1:0]          tmr_val;
  logic                      tmr_expired_c;

  ir_interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expired_c (tmr_expired_c)
  );

  // Next-state, datapath and line-level decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          state_d   = ST_SYNC;
          shift_d   = data_in;
          bit_cnt_d = '0;
          tmr_load  = 1'b1;
          tmr_val   = LD_SBD;
        end
      end
      ST_SYNC: begin
        if (tmr_expired_c) begin
          state_d  = ST_MARK;
          tmr_load = 1'b1;
          tmr_val  = LD_BSD;
        end
      end
      ST_MARK: begin
        if (tmr_expired_c) begin
          state_d  = ST_SPACE;
          tmr_load = 1'b1;
          tmr_val  = shift_q[MESSAGE_LENGTH-1] ? LD_BBD1 : LD_BBD0;
        end
      end
      ST_SPACE: begin
        if (tmr_expired_c) begin
          shift_d   = {shift_q[MESSAGE_LENGTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          tmr_load  = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_GAP;
            tmr_val = LD_GAP;
          end else begin
            state_d = ST_MARK;
            tmr_val = LD_BSD;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expired_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line is low only during sync and spaces; registered so it moves with the state.
    signal_d = !((state_d == ST_SYNC) || (state_d == ST_SPACE));
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      signal_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      signal_q  <= signal_d;
      done_q    <= done_d;
    end
  end

  assign ready_out  = (state_q == ST_IDLE);
  assign signal_out = signal_q;
  assign done_out   = done_q;
  assign state_out  = 3'(state_q);

endmodule

// File: tb/tb_ir_encoder.sv
// Bench for ir_encoder: random codes, a waveform model per code, and a line monitor that decodes frames.
module tb_ir_encoder;

  localparam int T_SBD  = 24;
  localparam int T_BSD  = 6;
  localparam int T_BBD0 = 6;
  localparam int T_BBD1 = 12;
  localparam int T_GAP  = 24;
  localparam int ML     = 8;
  localparam int NSEG   = 2 * ML + 2;

  typedef struct {
    logic [ML-1:0] code;
    int            seg[NSEG];
  } exp_t;

  logic          clk_in;
  logic          rst_in;
  logic [ML-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          signal_out;
  logic          done_out;
  logic [2:0]    state_out;

  ir_encoder #(
    .SBD (T_SBD), .BSD (T_BSD), .BBD0 (T_BBD0), .BBD1 (T_BBD1),
    .GAP (T_GAP), .MESSAGE_LENGTH (ML)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .signal_out (signal_out),
    .done_out   (done_out),
    .state_out  (state_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   obs[$];
  bit   in_frame = 0;
  bit   level = 1;
  int   run = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_acc = 0;
  int   last_done_cyc = -1000;
  int   start_gap = 0;
  int   last_len = 0;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Expected waveform built straight from the frame rules: sync, (mark, space by bit) per bit, gap.
  function automatic exp_t model(input logic [ML-1:0] code);
    exp_t e;
    int b;
    e.code   = code;
    e.seg[0] = T_SBD;
    for (int i = 0; i < ML; i++) begin
      b = (int'(code) >> (ML - 1 - i)) & 1;
      e.seg[1 + 2 * i] = T_BSD;
      e.seg[2 + 2 * i] = (b != 0) ? T_BBD1 : T_BBD0;
    end
    e.seg[NSEG-1] = T_GAP;
    return e;
  endfunction

  // Scoreboard producer: record the expected frame whenever a handshake occurs.
  initial begin
    forever begin
      @(posedge clk_in);
      if (!rst_in && valid_in && ready_out) begin
        exp_q.push_back(model(data_in));
        n_acc++;
      end
    end
  end

  // Monitor: measure line run lengths, and on done_out compare the frame against the scoreboard.
  initial begin
    exp_t e;
    int   sum_o, sum_e, code;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (rst_in) begin
        in_frame = 0;
        obs.delete();
        run = 0;
      end else if (done_out) begin
        n_done++;
        check("done_ready", int'(ready_out), 1);
        check("done_state", int'(state_out), 0);
        check("done_line", int'(signal_out), 1);
        if (!in_frame || exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          obs.push_back(run);
          in_frame = 0;
          e = exp_q.pop_front();
          check("seg_count", obs.size(), NSEG);
          if (obs.size() == NSEG) begin
            sum_o = 0;
            sum_e = 0;
            code  = 0;
            for (int i = 0; i < NSEG; i++) begin
              check($sformatf("seg%0d", i), obs[i], e.seg[i]);
              sum_o += obs[i];
              sum_e += e.seg[i];
            end
            for (int i = 0; i < ML; i++)
              code = (code << 1) | ((obs[2 + 2 * i] > (T_BBD0 + T_BBD1) / 2) ? 1 : 0);
            check("decoded_code", code, int'(e.code));
            check("frame_len", sum_o, sum_e);
            last_len = sum_o;
          end
        end
        last_done_cyc = cyc;
      end else if (in_frame) begin
        if (signal_out == level) begin
          run++;
        end else begin
          obs.push_back(run);
          level = signal_out;
          run = 1;
        end
      end else if (signal_out == 1'b0) begin
        in_frame  = 1;
        level     = 0;
        run       = 1;
        obs.delete();
        start_gap = cyc - last_done_cyc;
        check("start_state", int'(state_out), 1);
        check("start_ready", int'(ready_out), 0);
      end
    end
  end

  // Present one code for a single cycle once the encoder is ready.
  task automatic start(input logic [ML-1:0] code);
    int t = 0;
    @(negedge clk_in);
    while (!ready_out && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 1000) check("ready_timeout", 0, 1);
    data_in  = code;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Wiggle data_in and valid_in while busy; ends well before the shortest frame does.
  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      data_in  = ML'($urandom);
      valid_in = 1'($urandom_range(0, 1));
    end
    valid_in = 1'b0;
  endtask

  // Wait until every accepted frame has been reported, bounded.
  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || in_frame) && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 2000) check("frame_timeout", 0, 1);
  endtask

  initial begin
    int a0, t, d0;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk_in);
    check("rst_signal", int'(signal_out), 1);
    check("rst_done", int'(done_out), 0);
    check("rst_state", int'(state_out), 0);
    check("rst_ready", int'(ready_out), 1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("idle_signal", int'(signal_out), 1);
    check("idle_ready", int'(ready_out), 1);

    // 8'hA5: fixed frame length
    start(8'hA5);
    wait_idle();
    check("a5_len", last_len, 168);

    // All-zero and all-one codes with busy-time noise on the inputs
    start(8'h00);
    junk(60);
    wait_idle();
    check("00_len", last_len, 144);
    start(8'hFF);
    junk(60);
    wait_idle();
    check("ff_len", last_len, 192);

    // Back-to-back with valid held high: second frame starts right after done
    @(negedge clk_in);
    a0 = n_acc;
    data_in  = 8'h3C;
    valid_in = 1'b1;
    t = 0;
    while (n_acc < a0 + 1 && t < 100) begin @(negedge clk_in); t++; end
    data_in = 8'hC3;
    t = 0;
    while (n_acc < a0 + 2 && t < 1000) begin @(negedge clk_in); t++; end
    check("b2b_accepts", n_acc - a0, 2);
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_in);
    check("b2b_gap", start_gap, 1);
    wait_idle();

    // Asynchronous reset in the middle of bit 4 abandons the frame
    start(8'h5A);
    t = 0;
    while (obs.size() < 9 && t < 500) begin @(negedge clk_in); t++; end
    repeat (2) @(negedge clk_in);
    d0 = n_done;
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    check("arst_signal", int'(signal_out), 1);
    check("arst_state", int'(state_out), 0);
    check("arst_ready", int'(ready_out), 1);
    exp_q.delete();
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (250) @(negedge clk_in);
    check("arst_no_done", n_done, d0);
    start(8'h96);
    wait_idle();

    // Random codes with noise on the inputs while busy
    for (int k = 0; k < 20; k++) begin
      start(ML'($urandom));
      junk(int'($urandom_range(0, 100)));
      wait_idle();
    end

    check("queue_empty", exp_q.size(), 0);
    check("done_count", n_done, n_acc - 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
